// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch/decode constants and queue entry type
package instruction_fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_ALIGN = 4;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - in-order {pc,instr} queue with flush and combinational head
module instruction_fetch_unit_fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I fetch front end: PC generation, credit-limited issue, redirect flush
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_address
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            accept, resp_ok, push, pop;
  fetch_entry_t    head, push_entry;

  assign valid       = (count != '0);
  assign instruction = valid ? head.instr : NOP_INSTR;
  assign pc_address  = valid ? head.pc : '0;

  always_comb begin
    // Credit counts words in flight plus words queued, so a push can never overflow.
    credit_used = {1'b0, outstanding_q} + {1'b0, count};
    imem_req    = rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    imem_addr   = fetch_pc_q;
    accept      = imem_req && imem_ready;
    resp_ok     = imem_rvalid && (outstanding_q != '0);
    push        = resp_ok && (drop_q == '0) && !redirect;
    pop         = valid && !stall && !redirect;
    push_entry  = '{pc: resp_pc_q, instr: imem_rdata};

    outstanding_d = outstanding_q - CW'(resp_ok) + CW'(accept);
    drop_d        = drop_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;

    if (redirect) begin
      drop_d     = outstanding_q - CW'(resp_ok);
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
    end else begin
      if (resp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_ALIGN);
      if (push)   resp_pc_d  = resp_pc_q + XLEN'(INSTR_ALIGN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  instruction_fetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (count),
    .head_o      (head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc_address;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] mq_addr[$];
  int          mq_rdy[$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .valid       (valid),
    .instruction (instruction),
    .pc_address  (pc_address)
  );

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: consume the head if decode takes it, then advance the in-order memory model.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    if (valid && !stall && !redirect && rst) begin
      chk("pop_pc", pc_address, exp_pc);
      chk("pop_instr", instruction, word_for(exp_pc));
      exp_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      mq_addr.push_back(a);
      mq_rdy.push_back(cyc + lat - 1);
    end
    if (mq_addr.size() != 0 && mq_rdy[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_for(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
  endtask

  task automatic drain();
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (mq_addr.size() == 0 && !valid && !imem_rvalid) break;
      tick();
    end
    chk("drain_empty", {31'b0, valid}, 32'd0);
    chk("drain_outstanding", 32'(dut.outstanding_q), 32'd0);
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_pc", pc_address, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // 1: sequential fetch, 1-cycle memory
    rst = 1'b1; imem_ready = 1'b1; exp_pc = 32'h0;
    #1;
    chk("t1_req0", {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", {31'b0, valid}, 32'd0);
    tick();
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_valid1", {31'b0, valid}, 32'd0);
    tick();
    chk("t1_valid2", {31'b0, valid}, 32'd1);
    chk("t1_pc2", pc_address, 32'h0);
    chk("t1_addr2", imem_addr, 32'h8);
    tick();
    chk("t1_pc3", pc_address, 32'h4);
    chk("t1_addr3", imem_addr, 32'hC);

    // 2: memory not ready, request held, queue drains
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_req", {31'b0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr, 32'hC);
    end
    chk("t2_valid", {31'b0, valid}, 32'd0);
    chk("t2_instr", instruction, 32'h0000_0013);
    chk("t2_pc", pc_address, 32'h0);

    // 3: decode stall fills credit, release without loss
    stall = 1'b1; imem_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_req_cap", {31'b0, imem_req}, 32'd0);
    chk("t3_addr", imem_addr, 32'h1C);
    chk("t3_valid", {31'b0, valid}, 32'd1);
    chk("t3_pc_held", pc_address, 32'hC);
    chk("t3_instr_held", instruction, word_for(32'hC));
    stall = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) tick();
    drain();

    // 4: redirect with three stale requests in flight
    lat = 4; imem_ready = 1'b1;
    #1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h100; exp_pc = 32'h100;
    #1;
    chk("t4_req_redir", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_drop", 32'(dut.drop_q), 32'd3);
    chk("t4_outstanding", 32'(dut.outstanding_q), 32'd3);
    for (int i = 0; i < 12; i++) begin
      if (valid) break;
      tick();
    end
    chk("t4_first_valid", {31'b0, valid}, 32'd1);
    chk("t4_first_pc", pc_address, 32'h100);
    for (int i = 0; i < 4; i++) tick();
    drain();

    // 5: redirect coinciding with a response, unaligned target
    lat = 3; imem_ready = 1'b1;
    #1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h203; exp_pc = 32'h200;
    #1;
    chk("t5_req_redir", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_addr", imem_addr, 32'h200);
    chk("t5_drop", 32'(dut.drop_q), 32'd2);
    chk("t5_outstanding", 32'(dut.outstanding_q), 32'd2);
    chk("t5_valid", {31'b0, valid}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (valid) break;
      tick();
    end
    chk("t5_first_valid", {31'b0, valid}, 32'd1);
    chk("t5_first_pc", pc_address, 32'h200);
    for (int i = 0; i < 3; i++) tick();

    // 6: asynchronous reset with requests in flight
    for (int i = 0; i < 10; i++) begin
      if (mq_addr.size() >= 2) break;
      tick();
    end
    rst = 1'b0;
    #1;
    chk("t6_valid_rst", {31'b0, valid}, 32'd0);
    chk("t6_req_rst", {31'b0, imem_req}, 32'd0);
    chk("t6_outst_rst", 32'(dut.outstanding_q), 32'd0);
    rst = 1'b1; imem_ready = 1'b0; exp_pc = 32'h0;
    #1;
    chk("t6_addr_rel", imem_addr, 32'h0);
    chk("t6_req_rel", {31'b0, imem_req}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (mq_addr.size() == 0 && !imem_rvalid) break;
      tick();
    end
    chk("t6_late_outst", 32'(dut.outstanding_q), 32'd0);
    chk("t6_late_valid", {31'b0, valid}, 32'd0);
    chk("t6_late_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (valid) break;
      tick();
    end
    chk("t6_first_pc", pc_address, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
